// File: rtl/symbol_histogram.sv
// Per-frame symbol histogram for the Huffman front end: counts symbols 1..NUM_SYM plus an
// out-of-range bin, ends a frame on gray_last or an idle timeout, and pulses CNT_valid with the totals.
module symbol_histogram #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SYM_W    = 3,
  parameter int unsigned NUM_SYM  = 6,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned IDLE_CYC = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        gray_data,
  input  logic                     gray_valid,
  input  logic                     gray_last,
  output logic [NUM_SYM*CNT_W-1:0] CNT,
  output logic [CNT_W-1:0]         other_cnt,
  output logic                     sat,
  output logic                     busy,
  output logic                     CNT_valid
);

  localparam int unsigned IDLE_W = $clog2(IDLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t                   state, state_d;
  logic [IDLE_W-1:0]        idle_cnt, idle_cnt_d;
  logic [SYM_W-1:0]         sym;
  logic                     start;
  logic                     hit;
  logic [NUM_SYM*CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0]         other_d;
  logic                     sat_d;
  logic                     busy_d;
  logic                     valid_d;
  logic                     unused_upper;

  assign sym          = gray_data[SYM_W-1:0];
  assign unused_upper = ^gray_data[DATA_W-1:SYM_W];
  // A valid sample outside COUNT (IDLE or the DONE cycle) opens a new frame.
  assign start        = gray_valid && (state != S_COUNT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (gray_valid) state_d = gray_last ? S_DONE : S_COUNT;
        else            state_d = S_IDLE;
      end
      S_COUNT: begin
        if (gray_valid) begin
          if (gray_last) state_d = S_DONE;
        end else if (idle_cnt + IDLE_W'(1) == IDLE_W'(IDLE_CYC)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    busy_d     = (state_d == S_COUNT);
    valid_d    = (state_d == S_DONE);
    cnt_d      = CNT;
    other_d    = other_cnt;
    sat_d      = sat;
    hit        = 1'b0;
    idle_cnt_d = '0;
    if (state == S_COUNT && !gray_valid && state_d == S_COUNT) begin
      idle_cnt_d = idle_cnt + IDLE_W'(1);
    end
    if (start) begin
      cnt_d   = '0;
      other_d = '0;
      sat_d   = 1'b0;
    end
    if (gray_valid) begin
      for (int unsigned k = 1; k <= NUM_SYM; k++) begin
        if (sym == SYM_W'(k)) begin
          hit = 1'b1;
          if (cnt_d[(k-1)*CNT_W +: CNT_W] == CNT_MAX) sat_d = 1'b1;
          else cnt_d[(k-1)*CNT_W +: CNT_W] = cnt_d[(k-1)*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
      if (!hit) begin
        if (other_d == CNT_MAX) sat_d = 1'b1;
        else                    other_d = other_d + CNT_W'(1);
      end
    end
  end

  // Registered outputs and idle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      CNT       <= '0;
      other_cnt <= '0;
      sat       <= 1'b0;
      busy      <= 1'b0;
      CNT_valid <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      CNT       <= cnt_d;
      other_cnt <= other_d;
      sat       <= sat_d;
      busy      <= busy_d;
      CNT_valid <= valid_d;
      idle_cnt  <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_symbol_histogram.sv
// Scoreboard bench for symbol_histogram: default instance plus a 15-symbol/4-bit-count instance.
module tb_symbol_histogram;

  typedef struct packed {
    logic [15:0][7:0] cnt;
    logic [7:0]       other;
    logic             sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  a_data = '0, b_data = '0;
  logic        a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
  logic [47:0] a_cnt;
  logic [59:0] b_cnt;
  logic [7:0]  a_other;
  logic [3:0]  b_other;
  logic        a_sat, a_busy, a_cv, b_sat, b_busy, b_cv;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   m_cnt[16];
  int   m_other;
  bit   m_sat;
  bit   in_frame = 1'b0;

  always #5 clk = ~clk;

  symbol_histogram u_a (
    .clk(clk), .reset(reset), .gray_data(a_data), .gray_valid(a_valid), .gray_last(a_last),
    .CNT(a_cnt), .other_cnt(a_other), .sat(a_sat), .busy(a_busy), .CNT_valid(a_cv)
  );

  symbol_histogram #(.DATA_W(8), .SYM_W(4), .NUM_SYM(15), .CNT_W(4), .IDLE_CYC(4)) u_b (
    .clk(clk), .reset(reset), .gray_data(b_data), .gray_valid(b_valid), .gray_last(b_last),
    .CNT(b_cnt), .other_cnt(b_other), .sat(b_sat), .busy(b_busy), .CNT_valid(b_cv)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit to_b);
    exp_t e;
    e = '0;
    for (int k = 0; k < 16; k++) e.cnt[k] = 8'(m_cnt[k]);
    e.other = 8'(m_other);
    e.sat   = m_sat;
    if (to_b) qb.push_back(e);
    else      qa.push_back(e);
    in_frame = 1'b0;
  endtask

  // Reference histogram with saturation at maxv
  task automatic model_count(input int d, input int symw, input int nsym, input int maxv);
    int s;
    if (!in_frame) begin
      for (int k = 0; k < 16; k++) m_cnt[k] = 0;
      m_other  = 0;
      m_sat    = 1'b0;
      in_frame = 1'b1;
    end
    s = d % (1 << symw);
    if (s >= 1 && s <= nsym) begin
      if (m_cnt[s] == maxv) m_sat = 1'b1;
      else                  m_cnt[s]++;
    end else begin
      if (m_other == maxv) m_sat = 1'b1;
      else                 m_other++;
    end
  endtask

  task automatic send(input bit to_b, input int d, input bit last);
    if (!to_b) begin
      a_data = 8'(d); a_valid = 1'b1; a_last = last;
      model_count(d, 3, 6, 255);
    end else begin
      b_data = 8'(d); b_valid = 1'b1; b_last = last;
      model_count(d, 4, 15, 15);
    end
    if (last) push_exp(to_b);
    tick();
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0; a_last = 1'b0; b_valid = 1'b0; b_last = 1'b0;
    repeat (n) tick();
  endtask

  // Pop and compare whenever a CNT_valid pulse is seen
  always @(negedge clk) begin
    if (a_cv) begin
      if (qa.size() == 0) chk("a_unexpected_valid", longint'(a_cv), 0);
      else begin
        exp_t e;
        e = qa.pop_front();
        for (int k = 1; k <= 6; k++)
          chk($sformatf("a_cnt%0d", k), longint'(a_cnt[(k-1)*8 +: 8]), longint'(e.cnt[k]));
        chk("a_other", longint'(a_other), longint'(e.other));
        chk("a_sat", longint'(a_sat), longint'(e.sat));
        chk("a_busy_in_done", longint'(a_busy), 0);
      end
    end
    if (b_cv) begin
      if (qb.size() == 0) chk("b_unexpected_valid", longint'(b_cv), 0);
      else begin
        exp_t e;
        e = qb.pop_front();
        for (int k = 1; k <= 15; k++)
          chk($sformatf("b_cnt%0d", k), longint'(b_cnt[(k-1)*4 +: 4]), longint'(e.cnt[k]));
        chk("b_other", longint'(b_other), longint'(e.other));
        chk("b_sat", longint'(b_sat), longint'(e.sat));
      end
    end
  end

  initial begin
    int cyc;
    int f1[7] = '{1, 2, 2, 3, 6, 0, 7};
    #2;
    chk("rst_cnt", longint'(a_cnt), 0);
    chk("rst_other", longint'(a_other), 0);
    chk("rst_flags", longint'({a_sat, a_busy, a_cv}), 0);
    #10 reset = 1'b1;
    tick();

    // Frame ended by gray_last; upper data bits randomised
    for (int i = 0; i < 7; i++) send(1'b0, int'($urandom_range(0, 31)) * 8 + f1[i], i == 6);
    chk("last_latency_valid", longint'(a_cv), 1);
    idle(3);

    // Same samples ended by timeout, with a 3-cycle gap and a stray gray_last while idle
    for (int i = 0; i < 4; i++) send(1'b0, f1[i], 1'b0);
    idle(0);
    a_last = 1'b1;
    repeat (3) tick();
    a_last = 1'b0;
    chk("gap_busy", longint'(a_busy), 1);
    chk("gap_no_valid", longint'(a_cv), 0);
    for (int i = 4; i < 7; i++) send(1'b0, f1[i], 1'b0);
    push_exp(1'b0);
    idle(0);
    cyc = 0;
    while (!a_cv && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("timeout_latency", cyc, 4);
    idle(3);

    // Saturation, then a 1-sample frame clears sat
    for (int i = 0; i < 300; i++) send(1'b0, 4, i == 299);
    idle(2);
    send(1'b0, 4, 1'b1);
    idle(2);

    // Back-to-back: new frame starts during DONE
    send(1'b0, 1, 1'b0);
    send(1'b0, 2, 1'b0);
    send(1'b0, 3, 1'b1);
    chk("b2b_done_valid", longint'(a_cv), 1);
    send(1'b0, 5, 1'b0);
    chk("b2b_new_cnt", longint'(a_cnt), longint'(64'h1 << 32));
    chk("b2b_busy", longint'(a_busy), 1);
    chk("b2b_valid_low", longint'(a_cv), 0);
    send(1'b0, 2, 1'b1);
    idle(2);

    // Reset mid-frame aborts without a CNT_valid
    for (int i = 0; i < 10; i++) send(1'b0, (i % 7) + 1, 1'b0);
    a_valid = 1'b0;
    reset = 1'b0;
    in_frame = 1'b0;
    #1;
    chk("abort_cnt", longint'(a_cnt), 0);
    chk("abort_other", longint'(a_other), 0);
    chk("abort_flags", longint'({a_sat, a_busy, a_cv}), 0);
    tick();
    reset = 1'b1;
    idle(6);
    send(1'b0, 3, 1'b0);
    send(1'b0, 3, 1'b1);
    idle(2);

    // Wide-symbol instance: 1..15 once plus 17 x symbol 9, upper bits random
    for (int s = 1; s <= 15; s++) send(1'b1, int'($urandom_range(0, 15)) * 16 + s, 1'b0);
    for (int i = 0; i < 17; i++) send(1'b1, int'($urandom_range(0, 15)) * 16 + 9, i == 16);
    chk("b_done_valid", longint'(b_cv), 1);
    idle(4);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
